// File: rtl/prt_dp_pm_pkg.sv
// Shared definitions for the DP policy-maker peripherals.
// Holds local-bus register map, CTL/STS bit positions, HPD timing thresholds,
// the registered local-bus request struct and the HPD detector state type.
package prt_dp_pm_pkg;

  localparam int unsigned P_LB_ADR_W = 2;

  // Register map
  localparam logic [P_LB_ADR_W-1:0] P_ADR_CTL = 2'd0;
  localparam logic [P_LB_ADR_W-1:0] P_ADR_STS = 2'd1;
  localparam logic [P_LB_ADR_W-1:0] P_ADR_LOW = 2'd2;
  localparam logic [31:0]           P_RD_UNMAPPED = 32'hdeadcafe;

  // CTL bits
  localparam int unsigned P_CTL_RUN    = 0;
  localparam int unsigned P_CTL_IRQ_EN = 1;

  // STS bits
  localparam int unsigned P_STS_HPD     = 0;
  localparam int unsigned P_STS_PLUG    = 1;
  localparam int unsigned P_STS_UNPLUG  = 2;
  localparam int unsigned P_STS_IRQ_HPD = 3;

  // HPD thresholds in microseconds
  localparam int unsigned P_PLUG_US    = 2000;
  localparam int unsigned P_IRQ_MIN_US = 250;
  localparam int unsigned P_UNPLUG_US  = 2000;

  typedef struct packed {
    logic [P_LB_ADR_W-1:0] adr;
    logic                  rd;
    logic                  wr;
    logic [31:0]           din;
  } lb_struct;

  typedef enum logic [2:0] {
    sm_rst,
    sm_unplugged,
    sm_plug_wait,
    sm_plugged,
    sm_low
  } hpd_sm_t;

  // Threshold in beats; simulation builds shrink every window by 50.
  function automatic logic [15:0] thr(input int unsigned us, input int unsigned sim);
    return (sim != 0) ? 16'(us / 50) : 16'(us);
  endfunction

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local bus between the policy-maker CPU and its peripherals.
//   adr, rd, wr, din : request from the bus master
//   dout, vld        : read data and read-valid from the peripheral
// Modports: lb_out (master side), lb_in (peripheral side).
interface prt_dp_lb_if;
  import prt_dp_pm_pkg::*;

  logic [P_LB_ADR_W-1:0] adr;
  logic                  rd;
  logic                  wr;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic                  vld;

  modport lb_out (output adr, rd, wr, din, input dout, vld);
  modport lb_in  (input adr, rd, wr, din, output dout, vld);
endinterface

// File: rtl/prt_dp_lib_edge.sv
// Rising-edge detector.
//   CLK_IN, RST_IN : clock, asynchronous active-high reset
//   SIG_IN         : signal synchronous to CLK_IN
//   RE_OUT         : one-cycle pulse on each rising edge of SIG_IN
module prt_dp_lib_edge (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic SIG_IN,
  output logic RE_OUT
);

  logic sig_q;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= SIG_IN;
    end
  end

  assign RE_OUT = SIG_IN & ~sig_q;

endmodule

// File: rtl/prt_dp_pm_hpd_tx_sync.sv
// Two-flop synchronizer for the raw HPD pin.
//   CLK_IN, RST_IN : clock, asynchronous active-high reset (output resets to 0)
//   D_IN           : asynchronous input
//   Q_OUT          : D_IN synchronized to CLK_IN
module prt_dp_pm_hpd_tx_sync (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic D_IN,
  output logic Q_OUT
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= D_IN;
      sync_q <= meta_q;
    end
  end

  assign Q_OUT = sync_q;

endmodule

// File: rtl/prt_dp_pm_hpd_tx.sv
// Source-side HPD detector. Debounces HPD_IN against the 1 MHz beat and
// classifies it into plug, unplug and IRQ_HPD events, exposed as sticky W1C
// flags on the local bus, with a level interrupt toward the CPU.
//   RST_IN  : asynchronous active-high reset
//   CLK_IN  : clock
//   LB_IF   : local bus (CTL @0, STS @1, LOW_US @2)
//   BEAT_IN : 1 MHz beat, rising edge used
//   HPD_IN  : raw HPD pin, asynchronous
//   IRQ_OUT : registered interrupt, irq_en & any sticky event
module prt_dp_pm_hpd_tx
  import prt_dp_pm_pkg::*;
#(
  parameter int unsigned P_SIM = 0
) (
  input  logic            RST_IN,
  input  logic            CLK_IN,
  prt_dp_lb_if.lb_in      LB_IF,
  input  logic            BEAT_IN,
  input  logic            HPD_IN,
  output logic            IRQ_OUT
);

  localparam logic [15:0] C_PLUG    = thr(P_PLUG_US, P_SIM);
  localparam logic [15:0] C_IRQ_MIN = thr(P_IRQ_MIN_US, P_SIM);
  localparam logic [15:0] C_UNPLUG  = thr(P_UNPLUG_US, P_SIM);

  lb_struct    lb_q;
  logic        run_q, irq_en_q;
  logic        hpd_state_q, plug_q, unplug_q, irq_hpd_q;
  logic [15:0] low_us_q;
  logic [15:0] cnt_q;
  logic        irq_q;
  hpd_sm_t     sm_q, sm_d;

  logic        hpd_s;
  logic        beat_re;
  logic        set_plug, set_unplug, set_irq_hpd;
  logic        wr_ctl, wr_sts;
  logic [31:0] rd_data;
  logic        unused_din;

  prt_dp_pm_hpd_tx_sync u_sync (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .D_IN   (HPD_IN),
    .Q_OUT  (hpd_s)
  );

  prt_dp_lib_edge u_beat_edge (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .SIG_IN (BEAT_IN),
    .RE_OUT (beat_re)
  );

  // Local bus request register
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      lb_q <= '0;
    end else begin
      lb_q.adr <= LB_IF.adr;
      lb_q.rd  <= LB_IF.rd;
      lb_q.wr  <= LB_IF.wr;
      lb_q.din <= LB_IF.din;
    end
  end

  assign wr_ctl     = lb_q.wr && (lb_q.adr == P_ADR_CTL);
  assign wr_sts     = lb_q.wr && (lb_q.adr == P_ADR_STS);
  assign unused_din = ^lb_q.din[31:4];

  // FSM state register
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      sm_q <= sm_rst;
    end else begin
      sm_q <= sm_d;
    end
  end

  // FSM next state; the unplug window is tested first so a low pulse of
  // exactly the unplug length never becomes an IRQ_HPD.
  always_comb begin
    sm_d = sm_q;
    if (!run_q) begin
      sm_d = sm_rst;
    end else begin
      unique case (sm_q)
        sm_rst:       sm_d = sm_unplugged;
        sm_unplugged: if (hpd_s) sm_d = sm_plug_wait;
        sm_plug_wait: begin
          if (!hpd_s) sm_d = sm_unplugged;
          else if (cnt_q >= C_PLUG) sm_d = sm_plugged;
        end
        sm_plugged:   if (!hpd_s) sm_d = sm_low;
        sm_low: begin
          if (cnt_q >= C_UNPLUG) sm_d = sm_unplugged;
          else if (hpd_s) sm_d = sm_plugged;
        end
        default:      sm_d = sm_rst;
      endcase
    end
  end

  // FSM outputs: event set strobes
  always_comb begin
    set_plug    = 1'b0;
    set_unplug  = 1'b0;
    set_irq_hpd = 1'b0;
    if (run_q) begin
      unique case (sm_q)
        sm_plug_wait: set_plug = hpd_s && (cnt_q >= C_PLUG);
        sm_low: begin
          set_unplug  = (cnt_q >= C_UNPLUG);
          set_irq_hpd = !set_unplug && hpd_s && (cnt_q >= C_IRQ_MIN);
        end
        default: ;
      endcase
    end
  end

  // Control, status and counter registers. Event set has priority over W1C.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      hpd_state_q <= 1'b0;
      plug_q      <= 1'b0;
      unplug_q    <= 1'b0;
      irq_hpd_q   <= 1'b0;
      low_us_q    <= '0;
      cnt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_ctl) begin
        run_q    <= lb_q.din[P_CTL_RUN];
        irq_en_q <= lb_q.din[P_CTL_IRQ_EN];
      end
      if (!run_q) begin
        cnt_q       <= '0;
        hpd_state_q <= 1'b0;
        plug_q      <= 1'b0;
        unplug_q    <= 1'b0;
        irq_hpd_q   <= 1'b0;
      end else begin
        if (sm_d != sm_q) begin
          cnt_q <= '0;
        end else if (beat_re && (cnt_q != 16'hffff)) begin
          cnt_q <= cnt_q + 16'd1;
        end
        if (set_plug) begin
          hpd_state_q <= 1'b1;
        end else if (set_unplug || (sm_q == sm_rst)) begin
          hpd_state_q <= 1'b0;
        end
        plug_q    <= set_plug    | (plug_q    & ~(wr_sts & lb_q.din[P_STS_PLUG]));
        unplug_q  <= set_unplug  | (unplug_q  & ~(wr_sts & lb_q.din[P_STS_UNPLUG]));
        irq_hpd_q <= set_irq_hpd | (irq_hpd_q & ~(wr_sts & lb_q.din[P_STS_IRQ_HPD]));
      end
      if (set_irq_hpd) begin
        low_us_q <= cnt_q;
      end
      irq_q <= irq_en_q & (plug_q | unplug_q | irq_hpd_q);
    end
  end

  // Read mux
  always_comb begin
    rd_data = '0;
    if (lb_q.rd) begin
      case (lb_q.adr)
        P_ADR_CTL: begin
          rd_data[P_CTL_RUN]    = run_q;
          rd_data[P_CTL_IRQ_EN] = irq_en_q;
        end
        P_ADR_STS: begin
          rd_data[P_STS_HPD]     = hpd_state_q;
          rd_data[P_STS_PLUG]    = plug_q;
          rd_data[P_STS_UNPLUG]  = unplug_q;
          rd_data[P_STS_IRQ_HPD] = irq_hpd_q;
        end
        P_ADR_LOW: rd_data[15:0] = low_us_q;
        default:   rd_data = P_RD_UNMAPPED;
      endcase
    end
  end

  assign LB_IF.dout = rd_data;
  assign LB_IF.vld  = lb_q.rd;
  assign IRQ_OUT    = irq_q;

endmodule

// File: tb/tb_prt_dp_pm_hpd_tx.sv
// Bench for prt_dp_pm_hpd_tx in simulation mode (thresholds: plug/unplug 40
// beats, IRQ minimum 5 beats). Beat period is 10 clocks. Register reads push
// their expected value to a scoreboard and pop it when vld returns.
module tb_prt_dp_pm_hpd_tx;

  localparam logic [1:0] A_CTL = 2'd0;
  localparam logic [1:0] A_STS = 2'd1;
  localparam logic [1:0] A_LOW = 2'd2;

  logic CLK_IN = 1'b0;
  logic RST_IN;
  logic BEAT_IN = 1'b0;
  logic HPD_IN;
  logic IRQ_OUT;

  int bdiv   = 0;
  int beat_n = 0;
  int n_chk  = 0;
  int n_err  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          tol;
  } sb_t;
  sb_t sb[$];

  prt_dp_lb_if lb ();

  prt_dp_pm_hpd_tx #(.P_SIM(1)) dut (
    .RST_IN  (RST_IN),
    .CLK_IN  (CLK_IN),
    .LB_IF   (lb),
    .BEAT_IN (BEAT_IN),
    .HPD_IN  (HPD_IN),
    .IRQ_OUT (IRQ_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  always @(posedge CLK_IN) begin
    if (bdiv == 9) begin
      bdiv    <= 0;
      BEAT_IN <= 1'b1;
      beat_n  <= beat_n + 1;
    end else begin
      bdiv <= bdiv + 1;
      if (bdiv == 4) BEAT_IN <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int tol);
    logic [31:0] d;
    n_chk++;
    d = (obs > exp) ? obs - exp : exp - obs;
    if ($isunknown(obs) || d > 32'(tol)) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // All bus tasks start and end on a falling clock edge.
  task automatic lb_wr(input logic [1:0] a, input logic [31:0] d);
    lb.adr = a;
    lb.din = d;
    lb.wr  = 1'b1;
    @(negedge CLK_IN);
    lb.wr  = 1'b0;
  endtask

  task automatic lb_rd(input logic [1:0] a, input string tag, input logic [31:0] exp,
                       input int tol);
    sb_t e;
    int  cyc;
    e.tag = tag;
    e.exp = exp;
    e.tol = tol;
    sb.push_back(e);
    lb.adr = a;
    lb.rd  = 1'b1;
    @(negedge CLK_IN);
    lb.rd  = 1'b0;
    cyc = 0;
    while (lb.vld !== 1'b1 && cyc < 4) begin
      @(negedge CLK_IN);
      cyc++;
    end
    e = sb.pop_front();
    if (lb.vld === 1'b1) check(e.tag, lb.dout, e.exp, e.tol);
    else check({e.tag, "_vld"}, 32'(lb.vld), 32'd1, 0);
    @(negedge CLK_IN);
  endtask

  task automatic wait_beats(input int n);
    int b;
    b = beat_n;
    while (beat_n < b + n) @(negedge CLK_IN);
  endtask

  // Return on the falling edge just after a beat rising edge.
  task automatic align();
    wait_beats(1);
  endtask

  // Beats elapsed until IRQ_OUT reaches lvl; a timeout reports as too many beats.
  task automatic wait_irq_beats(input string tag, input logic lvl, input int exp_beats);
    int b0;
    int cyc;
    b0  = beat_n;
    cyc = 0;
    while (IRQ_OUT !== lvl && cyc < 700) begin
      @(negedge CLK_IN);
      cyc++;
    end
    check(tag, 32'(beat_n - b0), 32'(exp_beats), 2);
  endtask

  task automatic low_pulse(input int n);
    align();
    HPD_IN = 1'b0;
    wait_beats(n);
    HPD_IN = 1'b1;
    wait_beats(5);
  endtask

  initial begin
    int cyc;
    RST_IN = 1'b1;
    HPD_IN = 1'b0;
    lb.adr = '0;
    lb.rd  = 1'b0;
    lb.wr  = 1'b0;
    lb.din = '0;
    repeat (3) @(negedge CLK_IN);
    RST_IN = 1'b0;
    @(negedge CLK_IN);

    // Reset state
    check("rst_irq", 32'(IRQ_OUT), 32'd0, 0);
    check("rst_vld", 32'(lb.vld), 32'd0, 0);
    check("rst_dout", lb.dout, 32'd0, 0);
    lb_rd(A_CTL, "rst_ctl", 32'd0, 0);
    lb_rd(A_STS, "rst_sts", 32'd0, 0);
    lb_rd(A_LOW, "rst_low", 32'd0, 0);

    // Power-up with HPD low
    lb_wr(A_CTL, 32'd3);
    wait_beats(100);
    lb_rd(A_CTL, "ctl_rb", 32'd3, 0);
    lb_rd(A_STS, "pwr_sts", 32'd0, 0);
    check("pwr_irq", 32'(IRQ_OUT), 32'd0, 0);
    lb_rd(2'd3, "unmapped", 32'hdeadcafe, 0);

    // Plug
    align();
    HPD_IN = 1'b1;
    wait_irq_beats("plug_time", 1'b1, 40);
    lb_rd(A_STS, "plug_sts", 32'h3, 0);
    lb_wr(A_STS, 32'h2);
    cyc = 0;
    while (IRQ_OUT !== 1'b0 && cyc < 3) begin
      @(negedge CLK_IN);
      cyc++;
    end
    check("plug_w1c_irq", 32'(IRQ_OUT), 32'd0, 0);
    lb_rd(A_STS, "plug_clr_sts", 32'h1, 0);
    wait_beats(10);

    // IRQ_HPD pulse
    low_pulse(15);
    lb_rd(A_STS, "irqhpd_sts", 32'h9, 0);
    lb_rd(A_LOW, "irqhpd_low", 32'd15, 2);
    check("irqhpd_irq", 32'(IRQ_OUT), 32'd1, 0);
    lb_wr(A_STS, 32'h8);

    // Glitch
    low_pulse(2);
    lb_rd(A_STS, "glitch_sts", 32'h1, 0);
    lb_rd(A_LOW, "glitch_low", 32'd15, 2);
    check("glitch_irq", 32'(IRQ_OUT), 32'd0, 0);

    // Just below the unplug window
    low_pulse(39);
    lb_rd(A_STS, "p39_sts", 32'h9, 0);
    lb_rd(A_LOW, "p39_low", 32'd39, 2);
    lb_wr(A_STS, 32'h8);

    // Unplug
    align();
    HPD_IN = 1'b0;
    wait_irq_beats("unplug_time", 1'b1, 40);
    lb_rd(A_STS, "unplug_sts", 32'h4, 0);
    wait_beats(20);
    lb_wr(A_STS, 32'h4);

    // Replug
    align();
    HPD_IN = 1'b1;
    wait_irq_beats("replug_time", 1'b1, 40);
    lb_wr(A_STS, 32'h2);
    wait_beats(5);

    // W1C lands on the same edge as the irq_hpd set
    align();
    HPD_IN = 1'b0;
    wait_beats(10);
    HPD_IN = 1'b1;
    @(negedge CLK_IN);
    lb_wr(A_STS, 32'h8);
    wait_beats(2);
    lb_rd(A_STS, "coll_sts", 32'h9, 0);
    lb_rd(A_LOW, "coll_low", 32'd10, 2);

    // Drop run while low
    align();
    HPD_IN = 1'b0;
    wait_beats(5);
    lb_wr(A_CTL, 32'h2);
    repeat (3) @(negedge CLK_IN);
    check("drop_irq", 32'(IRQ_OUT), 32'd0, 0);
    lb_rd(A_STS, "drop_sts", 32'h0, 0);
    lb_rd(A_LOW, "drop_low", 32'd10, 2);
    HPD_IN = 1'b1;
    wait_beats(45);
    check("halt_irq", 32'(IRQ_OUT), 32'd0, 0);
    lb_rd(A_STS, "halt_sts", 32'h0, 0);

    // Re-run with HPD already high
    align();
    lb_wr(A_CTL, 32'h3);
    wait_irq_beats("rerun_time", 1'b1, 40);
    lb_rd(A_STS, "rerun_sts", 32'h3, 0);

    check("sb_drain", 32'(sb.size()), 32'd0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
